etap_tap_ctrl: RTL and testbench

- IEEE 1149.1 TAP state machine plus 5-bit EJTAG instruction register for the SchoolMIPS debug port.
- Decodes the current instruction into the 4-bit data-register select that steers the DR multiplexer.
- Sequences the DR strobes (shift_dr, clk_dr, update_dr) and drives tdo from either the IR or the selected DR serial output.
- Sits between the external JTAG pins and the DR mux / EJTAG registers, all in the tck domain.

---
 rtl/etap_tap_ctrl_if.sv | 32 +++
 rtl/etap_tap_ctrl.sv | 118 +++++++++++
 tb/tb_etap_tap_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/etap_tap_ctrl_if.sv
// JTAG pin / DR-mux side signals of the EJTAG TAP controller.
// The master modport is the TAP controller.
// The slave modport is the pin driver and DR mux around it.
interface etap_tap_ctrl_if #(
    parameter int IR_W = 5
);
    logic            tms;
    logic            tdi;
    logic            tdo;
    logic            tdo_oe;
    logic            dr_tdo;
    logic [3:0]      sel;
    logic            capture_dr;
    logic            shift_dr;
    logic            clk_dr;
    logic            update_dr;
    logic [3:0]      tap_state;
    logic [IR_W-1:0] ir_value;
    logic            tlr;

    modport master (
        input  tms, tdi, dr_tdo,
        output tdo, tdo_oe, sel, capture_dr, shift_dr, clk_dr, update_dr,
               tap_state, ir_value, tlr
    );

    modport slave (
        output tms, tdi, dr_tdo,
        input  tdo, tdo_oe, sel, capture_dr, shift_dr, clk_dr, update_dr,
               tap_state, ir_value, tlr
    );
endinterface

// File: rtl/etap_tap_ctrl.sv
// IEEE 1149.1 TAP state machine with a 5-bit EJTAG instruction register.
// It decodes the instruction into the DR-mux select and sequences the DR strobes.
// Everything runs in the tck domain.
module etap_tap_ctrl #(
    parameter int              IR_W       = 5,
    parameter logic [IR_W-1:0] IR_CAPTURE = 5'b00001,
    parameter logic [IR_W-1:0] IR_RESET   = 5'h01
) (
    input  logic           tck,
    input  logic           trst_n,
    etap_tap_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    tap_state_t      state_reg;
    logic [IR_W-1:0] ir_shift_reg;
    logic [IR_W-1:0] ir_value_reg;
    logic [3:0]      sel_reg;

    // Standard TAP transition table; tms=1 five times always lands in TLR.
    function automatic tap_state_t next_state(input tap_state_t s, input logic t);
        tap_state_t n;
        case (s)
            TLR:    n = t ? TLR    : RTI;
            RTI:    n = t ? SEL_DR : RTI;
            SEL_DR: n = t ? SEL_IR : CAP_DR;
            CAP_DR: n = t ? EX1_DR : SH_DR;
            SH_DR:  n = t ? EX1_DR : SH_DR;
            EX1_DR: n = t ? UPD_DR : PAU_DR;
            PAU_DR: n = t ? EX2_DR : PAU_DR;
            EX2_DR: n = t ? UPD_DR : SH_DR;
            UPD_DR: n = t ? SEL_DR : RTI;
            SEL_IR: n = t ? TLR    : CAP_IR;
            CAP_IR: n = t ? EX1_IR : SH_IR;
            SH_IR:  n = t ? EX1_IR : SH_IR;
            EX1_IR: n = t ? UPD_IR : PAU_IR;
            PAU_IR: n = t ? EX2_IR : PAU_IR;
            EX2_IR: n = t ? UPD_IR : SH_IR;
            UPD_IR: n = t ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    // Instruction code to DR-mux index; anything unrecognised selects BYPASS.
    function automatic logic [3:0] decode_sel(input logic [IR_W-1:0] ir);
        logic [3:0] s;
        case (ir)
            IR_W'(5'h01): s = 4'd0;   // IDCODE
            IR_W'(5'h03): s = 4'd1;   // IMPCODE
            IR_W'(5'h08): s = 4'd2;   // ADDRESS
            IR_W'(5'h09): s = 4'd3;   // DATA
            IR_W'(5'h0A): s = 4'd4;   // CONTROL
            IR_W'(5'h0C): s = 4'd5;   // EJTAGBOOT
            IR_W'(5'h02): s = 4'd6;   // SAMPLE_PRELOAD
            default:      s = 4'd7;   // BYPASS
        endcase
        return s;
    endfunction

    // TAP state, IR shift stage, and the committed instruction with its decoded select.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_reg    <= TLR;
            ir_shift_reg <= '0;
            ir_value_reg <= IR_RESET;
            sel_reg      <= decode_sel(IR_RESET);
        end else begin
            state_reg <= next_state(state_reg, bus.tms);
            case (state_reg)
                TLR: begin
                    ir_value_reg <= IR_RESET;
                    sel_reg      <= decode_sel(IR_RESET);
                end
                CAP_IR: ir_shift_reg <= IR_CAPTURE;
                SH_IR:  ir_shift_reg <= {bus.tdi, ir_shift_reg[IR_W-1:1]};
                UPD_IR: begin
                    // Commit on the edge leaving UPD_IR; sel follows in the same edge.
                    ir_value_reg <= ir_shift_reg;
                    sel_reg      <= decode_sel(ir_shift_reg);
                end
                default: ;
            endcase
        end
    end

    // Strobes and tdo decode from the state register only, so tms has no combinational path to them.
    assign bus.capture_dr = (state_reg == CAP_DR);
    assign bus.shift_dr   = (state_reg == SH_DR);
    assign bus.update_dr  = (state_reg == UPD_DR);
    assign bus.clk_dr     = (state_reg == CAP_DR) || (state_reg == SH_DR);
    assign bus.tlr        = (state_reg == TLR);
    assign bus.tdo_oe     = (state_reg == SH_IR) || (state_reg == SH_DR);
    assign bus.tdo        = (state_reg == SH_IR) ? ir_shift_reg[0] :
                            (state_reg == SH_DR) ? bus.dr_tdo      : 1'b0;
    assign bus.tap_state  = state_reg;
    assign bus.ir_value   = ir_value_reg;
    assign bus.sel        = sel_reg;

endmodule

// File: tb/tb_etap_tap_ctrl.sv
// Directed bench for etap_tap_ctrl.
// It covers reset state, IR loads, decode, a DR scan, pause and the resets.
module tb_etap_tap_ctrl;

    logic tck;
    logic trst_n;
    int   n_cmp;
    int   n_err;

    etap_tap_ctrl_if #(.IR_W(5)) bus ();

    etap_tap_ctrl dut (
        .tck    (tck),
        .trst_n (trst_n),
        .bus    (bus)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge and let one rising edge pass.
    // Outputs are then stable for checking.
    task automatic step(input logic t, input logic d, input logic r);
        @(negedge tck);
        bus.tms    = t;
        bus.tdi    = d;
        bus.dr_tdo = r;
        @(posedge tck);
        #1;
    endtask

    // Load a 5-bit instruction LSB first from RTI; ends in RTI.
    task automatic load_ir(input logic [4:0] code);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 5; i++) step(i == 4, code[i], 0);
        step(1, 0, 0); step(0, 0, 0);
    endtask

    logic [35:0] pat;
    logic [4:0]  tdo_exp;
    logic        upd_seen;
    logic        in_shift;

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.tms    = 1'b1;
        bus.tdi    = 1'b0;
        bus.dr_tdo = 1'b0;
        trst_n     = 1'b0;
        #12;
        chk("rst_state", 32'(bus.tap_state), 32'hF);
        chk("rst_tlr", 32'(bus.tlr), 32'd1);
        chk("rst_ir", 32'(bus.ir_value), 32'h01);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_tdo_oe", 32'(bus.tdo_oe), 32'd0);
        chk("rst_strobes", 32'({bus.capture_dr, bus.shift_dr, bus.clk_dr, bus.update_dr}), 32'd0);
        @(negedge tck);
        trst_n = 1'b1;

        // TLR -> RTI
        step(0, 0, 0);
        chk("to_rti", 32'(bus.tap_state), 32'hC);

        // IR load DATA (09), checking tdo while shifting.
        tdo_exp = 5'b00001;   // expected tdo sequence LSB first: 1,0,0,0,0
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
        chk("cap_ir", 32'(bus.tap_state), 32'hE);
        step(0, 0, 0);
        chk("sh_ir", 32'(bus.tap_state), 32'hA);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ir_tdo%0d", i), 32'(bus.tdo), 32'(tdo_exp[i]));
            chk($sformatf("ir_oe%0d", i), 32'(bus.tdo_oe), 32'd1);
            step(i == 4, (5'b01001 >> i) & 5'd1, 0);
        end
        chk("ex1_ir", 32'(bus.tap_state), 32'h9);
        step(1, 0, 0);
        chk("upd_ir", 32'(bus.tap_state), 32'hD);
        chk("upd_ir_sel_old", 32'(bus.sel), 32'd0);
        step(0, 0, 0);
        chk("data_ir", 32'(bus.ir_value), 32'h09);
        chk("data_sel", 32'(bus.sel), 32'd3);

        // Unknown opcode -> BYPASS
        load_ir(5'h15);
        chk("unk_ir", 32'(bus.ir_value), 32'h15);
        chk("unk_sel", 32'(bus.sel), 32'd7);

        // CONTROL opcode
        load_ir(5'h0A);
        chk("ctl_sel", 32'(bus.sel), 32'd4);

        // Five tms=1 from RTI reach TLR; TLR reloads IDCODE.
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk("tlr_state", 32'(bus.tap_state), 32'hF);
        chk("tlr_ir", 32'(bus.ir_value), 32'h01);
        chk("tlr_sel", 32'(bus.sel), 32'd0);
        step(0, 0, 0);

        // DR scan of 32 bits with sel=0.
        pat = 36'h9_A5C3_1E6B;
        for (int k = 0; k < 36; k++) begin
            step((k == 0 || k >= 34), 0, pat[k]);
            in_shift = (k >= 2 && k <= 33);
            chk($sformatf("dr_cap%0d", k), 32'(bus.capture_dr), 32'(k == 1));
            chk($sformatf("dr_sh%0d", k), 32'(bus.shift_dr), 32'(in_shift));
            chk($sformatf("dr_clk%0d", k), 32'(bus.clk_dr), 32'(k >= 1 && k <= 33));
            chk($sformatf("dr_upd%0d", k), 32'(bus.update_dr), 32'(k == 35));
            chk($sformatf("dr_tdo%0d", k), 32'(bus.tdo), in_shift ? 32'(pat[k]) : 32'd0);
        end
        step(0, 0, 0);
        chk("dr_back_rti", 32'(bus.tap_state), 32'hC);
        chk("dr_ir_kept", 32'(bus.ir_value), 32'h01);

        // Pause inside a DR scan.
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0); step(0, 0, 0);
        chk("pau_dr", 32'(bus.tap_state), 32'h3);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1);
            chk($sformatf("pau_str%0d", i),
                32'({bus.capture_dr, bus.shift_dr, bus.clk_dr, bus.update_dr, bus.tdo_oe}), 32'd0);
        end
        step(1, 0, 0);
        chk("ex2_dr", 32'(bus.tap_state), 32'h0);
        step(0, 0, 0);
        chk("resume_sh", 32'(bus.shift_dr), 32'd1);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);

        // Synchronous reset from PAU_IR with five tms=1.
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0); step(0, 0, 0);
        chk("pau_ir", 32'(bus.tap_state), 32'hB);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        chk("pre_tlr", 32'(bus.tap_state), 32'h4);
        step(1, 0, 0);
        chk("sync_tlr", 32'(bus.tap_state), 32'hF);
        step(0, 0, 0);
        chk("sync_rti", 32'(bus.tap_state), 32'hC);

        // Asynchronous reset in the middle of a DR scan.
        load_ir(5'h09);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 1);
        chk("mid_sh", 32'(bus.tap_state), 32'h2);
        #2;
        trst_n = 1'b0;
        #1;
        chk("mid_state", 32'(bus.tap_state), 32'hF);
        chk("mid_tlr", 32'(bus.tlr), 32'd1);
        chk("mid_sel", 32'(bus.sel), 32'd0);
        chk("mid_ir", 32'(bus.ir_value), 32'h01);
        chk("mid_out", 32'({bus.capture_dr, bus.shift_dr, bus.clk_dr, bus.update_dr,
                            bus.tdo_oe, bus.tdo}), 32'd0);
        upd_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1);
            upd_seen = upd_seen | bus.update_dr;
        end
        @(negedge tck);
        trst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1);
            upd_seen = upd_seen | bus.update_dr;
        end
        chk("mid_no_upd", 32'(upd_seen), 32'd0);
        chk("mid_after", 32'(bus.tap_state), 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
